// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the safe-softmax normalizer.
// Values are Q2.13: sign, 2 integer bits, 13 fraction bits.
package softmax_pkg;

    localparam int          FRAC_W      = 13;
    localparam logic [15:0] ONE_Q       = 16'h2000;
    localparam int          RECIP_SHIFT = 28;
    localparam int          OUT_SHIFT   = 15;
    localparam int          DIV_CYCLES  = 16;

    typedef enum logic [1:0] {
        LOAD,
        DIV,
        OUT
    } state_t;

endpackage

// File: rtl/recip_div_seq.sv
// Sequential restoring divider: quotient = floor(2^RECIP_SHIFT / divisor).
// It produces one quotient bit per cycle, MSB first, and pulses done after DIV_CYCLES steps.
module recip_div_seq
    import softmax_pkg::*;
#(
    parameter int SUM_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] divisor,
    output logic             done,
    output logic [15:0]      quotient
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    // The upper dividend bits seed the remainder. This is valid because divisor >= 2^13 > 2^12.
    localparam logic [SUM_W-1:0] REM_INIT = SUM_W'(1) << (RECIP_SHIFT - DIV_CYCLES);

    logic [SUM_W-1:0] rem;
    logic [SUM_W-1:0] dvs;
    logic [SUM_W:0]   shifted;
    logic             fits;
    logic [CNT_W-1:0] cnt;
    logic             busy;

    assign shifted = {rem, 1'b0};
    assign fits    = shifted >= {1'b0, dvs};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem      <= REM_INIT;
                dvs      <= divisor;
                cnt      <= '0;
                busy     <= 1'b1;
                quotient <= '0;
            end else if (busy) begin
                rem      <= fits ? SUM_W'(shifted - {1'b0, dvs}) : SUM_W'(shifted);
                quotient <= {quotient[14:0], fits};
                cnt      <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/safe_softmax_norm.sv
// Buffers one row of exponent values, sums them, divides once to form a reciprocal,
// then streams out p_i = e_i * recip >> 15 in Q2.13.
module safe_softmax_norm
    import softmax_pkg::*;
#(
    parameter int D_W     = 16,
    parameter int SEQ_LEN = 4,
    parameter int SUM_W   = D_W + $clog2(SEQ_LEN)
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_VALID,
    output logic           O_READY,
    input  logic [D_W-1:0] I_DATA,
    output logic           O_VALID,
    input  logic           I_READY,
    output logic [D_W-1:0] O_DATA,
    output logic           O_LAST,
    output logic           O_ERR,
    output logic           O_BUSY
);

    localparam int               IDX_W    = $clog2(SEQ_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] in_cnt;
    logic [IDX_W-1:0] out_idx;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] sum_next;
    logic [SUM_W-1:0] divisor;
    logic [D_W-1:0]   data_mag;
    logic [D_W-1:0]   recip;
    logic [D_W-1:0]   row_buf [SEQ_LEN];
    logic [2*D_W-1:0] product;
    logic [15:0]      quotient;
    logic             accept;
    logic             last_in;
    logic             out_fire;
    logic             underflow;
    logic             div_done;
    logic             err;

    // Negative exponents are clamped to zero both in the sum and in the stored value.
    assign data_mag  = I_DATA[D_W-1] ? '0 : {1'b0, I_DATA[D_W-2:0]};
    assign accept    = I_VALID && (state == LOAD);
    assign last_in   = accept && (in_cnt == LAST_IDX);
    assign sum_next  = sum + SUM_W'(data_mag);
    assign underflow = sum_next < SUM_W'(ONE_Q);
    assign divisor   = underflow ? SUM_W'(ONE_Q) : sum_next;
    assign out_fire  = (state == OUT) && I_READY;

    recip_div_seq #(
        .SUM_W(SUM_W)
    ) u_div (
        .clk     (I_CLK),
        .rst_n   (I_RST_N),
        .start   (last_in),
        .divisor (divisor),
        .done    (div_done),
        .quotient(quotient)
    );

    always_ff @(posedge I_CLK) begin
        if (accept) begin
            row_buf[in_cnt] <= data_mag;
        end
    end

    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            state   <= LOAD;
            in_cnt  <= '0;
            out_idx <= '0;
            sum     <= '0;
            recip   <= '0;
            err     <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                sum    <= sum_next;
                in_cnt <= last_in ? '0 : in_cnt + IDX_W'(1);
                if (last_in) begin
                    err <= underflow;
                end
            end
            if (div_done) begin
                recip <= quotient;
            end
            if (out_fire) begin
                if (out_idx == LAST_IDX) begin
                    out_idx <= '0;
                    sum     <= '0;
                    err     <= 1'b0;
                end else begin
                    out_idx <= out_idx + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        O_READY    = 1'b0;
        O_VALID    = 1'b0;
        case (state)
            LOAD: begin
                O_READY = 1'b1;
                if (last_in) state_next = DIV;
            end
            DIV: begin
                if (div_done) state_next = OUT;
            end
            OUT: begin
                O_VALID = 1'b1;
                if (out_fire && (out_idx == LAST_IDX)) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    // Outputs depend only on registers, so a stall keeps them stable.
    assign product = row_buf[out_idx] * recip;
    assign O_DATA  = D_W'(product >> OUT_SHIFT);
    assign O_LAST  = (state == OUT) && (out_idx == LAST_IDX);
    assign O_ERR   = err;
    assign O_BUSY  = !((state == LOAD) && (in_cnt == '0));

endmodule

// File: tb/tb_safe_softmax_norm.sv
// Self-checking bench for safe_softmax_norm: directed rows from the test plan plus
// random rows compared against an arithmetic softmax-normalization model.
module tb_safe_softmax_norm;

    localparam int SEQ_LEN = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        up_valid = 1'b0;
    logic        up_ready;
    logic [15:0] up_data = '0;
    logic        dn_valid;
    logic        dn_ready = 1'b0;
    logic [15:0] dn_data;
    logic        dn_last;
    logic        err;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc = 0;

    logic [15:0] row_in  [SEQ_LEN];
    logic [15:0] exp_out [SEQ_LEN];
    logic        exp_err;

    safe_softmax_norm #(
        .D_W(16),
        .SEQ_LEN(SEQ_LEN)
    ) dut (
        .I_CLK  (clk),
        .I_RST_N(rst_n),
        .I_VALID(up_valid),
        .O_READY(up_ready),
        .I_DATA (up_data),
        .O_VALID(dn_valid),
        .I_READY(dn_ready),
        .O_DATA (dn_data),
        .O_LAST (dn_last),
        .O_ERR  (err),
        .O_BUSY (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: p_i = floor(e_i * floor(2^28 / sum) / 2^15), where an underflowing sum is treated as 1.0.
    task automatic modelRow();
        longint total;
        longint recip_m;
        longint mag;
        total = 0;
        for (int i = 0; i < SEQ_LEN; i++) begin
            total += row_in[i][15] ? 0 : longint'(row_in[i]);
        end
        exp_err = (total < 'h2000);
        recip_m = exp_err ? 'h8000 : ((longint'(1) << 28) / total);
        for (int i = 0; i < SEQ_LEN; i++) begin
            mag = row_in[i][15] ? 0 : longint'(row_in[i]);
            exp_out[i] = 16'((mag * recip_m) >> 15);
        end
    endtask

    task automatic applyStimulus(input bit hold_valid);
        int waited;
        @(posedge clk);
        #1;
        for (int i = 0; i < SEQ_LEN; i++) begin
            up_valid = 1'b1;
            up_data  = row_in[i];
            waited   = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!up_ready && waited < 50);
            checkOutput($sformatf("in_ready%0d", i), up_ready, 1);
            @(posedge clk);
            #1;
        end
        last_acc = cyc;
        if (hold_valid) up_data = 16'h1234;
        else up_valid = 1'b0;
    endtask

    task automatic receiveRow(input bit backpressure);
        logic [3:0] pattern;
        bit  seen;
        bit  rdy;
        int  idx;
        int  k;
        int  bound;
        pattern = 4'b1001;
        seen = 0;
        idx = 0;
        k = 0;
        bound = 0;
        modelRow();
        while (idx < SEQ_LEN && bound < 100) begin
            @(negedge clk);
            bound++;
            checkOutput("ready_low", up_ready, 0);
            if (dn_valid) begin
                if (!seen) begin
                    seen = 1;
                    checkOutput("latency", cyc - last_acc, 17);
                end
                checkOutput($sformatf("data%0d", idx), dn_data, exp_out[idx]);
                checkOutput($sformatf("last%0d", idx), dn_last, (idx == SEQ_LEN - 1));
                checkOutput("err_out", err, exp_err);
                rdy = backpressure ? pattern[k % 4] : 1'b1;
                k++;
                dn_ready = rdy;
                if (rdy) begin
                    idx++;
                    if (idx == SEQ_LEN) up_valid = 1'b0;
                end
            end else begin
                checkOutput("busy_div", busy, 1);
            end
        end
        checkOutput("row_complete", idx, SEQ_LEN);
        @(negedge clk);
        dn_ready = 1'b0;
        checkOutput("idle_valid", dn_valid, 0);
        checkOutput("idle_err", err, 0);
        checkOutput("idle_busy", busy, 0);
    endtask

    initial begin
        bit seen_v;
        logic [15:0] v;

        $display("[TB] reset");
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", up_ready, 1);
        checkOutput("rst_valid", dn_valid, 0);
        checkOutput("rst_last", dn_last, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;

        $display("[TB] uniform row");
        row_in = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        applyStimulus(0);
        receiveRow(0);

        $display("[TB] mixed row");
        row_in = '{16'h2000, 16'h1000, 16'h1000, 16'h0000};
        applyStimulus(0);
        receiveRow(0);

        $display("[TB] single one row");
        row_in = '{16'h2000, 16'h0000, 16'h0000, 16'h0000};
        applyStimulus(0);
        receiveRow(0);

        $display("[TB] underflow row");
        row_in = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        applyStimulus(0);
        receiveRow(0);

        $display("[TB] backpressure row with valid held high");
        row_in = '{16'h2000, 16'h1000, 16'h0800, 16'h0400};
        applyStimulus(1);
        receiveRow(1);

        $display("[TB] reset during division");
        row_in = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
        applyStimulus(0);
        repeat (8) @(negedge clk);
        checkOutput("err_mid_div", err, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", dn_valid, 0);
        checkOutput("abort_err", err, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_ready", up_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen_v = 0;
        repeat (20) begin
            @(negedge clk);
            if (dn_valid) seen_v = 1;
        end
        checkOutput("no_output_after_reset", seen_v, 0);
        row_in = '{16'h2000, 16'h2000, 16'h2000, 16'h2000};
        applyStimulus(0);
        receiveRow(0);

        $display("[TB] random rows");
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < SEQ_LEN; i++) begin
                v = 16'($urandom_range(0, 'h2000));
                if (r % 3 == 2) v = v >> 3;
                if ($urandom_range(0, 7) == 0) v = 16'($urandom) | 16'h8000;
                row_in[i] = v;
            end
            applyStimulus(0);
            receiveRow(r % 2 == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/safe_softmax_norm.md
Name: safe_softmax_norm

Overview:
Consumer and normalizer for the 2^x exponent-LUT output stream in the safe-softmax path. It takes SEQ_LEN exponent values in signed Q2.13, buffers them, and accumulates their sum. It then computes a reciprocal with a sequential restoring divider and streams back the normalized probabilities p_i = e_i / sum in Q2.13. It sits between the exponent LUT stage and the attention-weight x V multiply.

Parameters:
D_W, 16, data width; only 16 (Q2.13: sign, 2 integer bits, 13 fraction bits; 1.0 = 16'h2000) is supported.
SEQ_LEN, 4, number of exponent values per softmax row; 2..64.
SUM_W, D_W+$clog2(SEQ_LEN), accumulator width (unsigned).

Ports:
I_CLK  input  1  clock, rising edge.
I_RST_N  input  1  asynchronous active-low reset.
I_VALID  input  1  upstream exponent value valid.
O_READY  output  1  block can accept I_DATA.
I_DATA  input  D_W  exponent value, Q2.13; range 0..16'h2000.
O_VALID  output  1  normalized value valid.
I_READY  input  1  downstream accepts O_DATA.
O_DATA  output  D_W  normalized probability, Q2.13.
O_LAST  output  1  high with the SEQ_LEN-th output of a row.
O_ERR  output  1  sum underflow flag for the current row.
O_BUSY  output  1  high in any state other than LOAD with count 0.

Behaviour:
- Reset (async, I_RST_N low): state LOAD; in_cnt, out_idx, sum, recip and O_ERR cleared. O_READY=1, O_VALID=0, O_LAST=0, O_ERR=0, O_BUSY=0. The buffer is not reset.
- FSM states are LOAD, DIV and OUT.
- LOAD:
  - O_READY=1. Each I_VALID&O_READY edge writes buf[in_cnt] and adds I_DATA[D_W-2:0] (magnitude, zero-extended) to sum. A negative I_DATA (sign bit 1) is treated as 0.
  - On the accept with in_cnt==SEQ_LEN-1, go to DIV and clear in_cnt.
- DIV:
  - O_READY=0. The restoring divider computes recip = floor(2^28 / sum) in 16-bit unsigned, one quotient bit per cycle, MSB first. DIV lasts exactly 16 cycles.
  - Error rule: if sum < 16'h2000 on DIV entry, set O_ERR=1, skip the division result and force recip=16'h8000 (treat sum as 1.0). DIV still takes 16 cycles.
  - Because sum>=2^13, the quotient fits 16 bits (max 2^15).
- OUT:
  - O_VALID=1. O_DATA = (buf[out_idx] * recip) >> 15, truncated, with the 29-bit product unsigned. O_DATA is computed combinationally from registers only; there is no path from I_* to O_*.
  - out_idx advances on O_VALID&I_READY. O_LAST = (out_idx==SEQ_LEN-1).
  - On the final handshake: go to LOAD, clear sum, out_idx and O_ERR. O_ERR holds for the whole OUT phase of the errored row.
  - While I_READY=0, O_DATA and O_LAST hold stable.
- Latency: O_VALID first rises 17 cycles after the edge that accepted the last input (16 DIV cycles plus 1 transition).
- Throughput: one row per SEQ_LEN+16+SEQ_LEN cycles at full handshake. Rows are not overlapped.
- Boundary conditions:
  - Max sum is SEQ_LEN*2^13, which never overflows SUM_W.
  - Input of all-zero except one 1.0 gives recip = 16'h8000.
  - Reset mid-DIV or mid-OUT aborts the row; no partial output follows reset.

Decomposition:
- Package softmax_pkg holds:
  - Q-format constants: FRAC_W=13, ONE_Q=16'h2000.
  - RECIP_SHIFT=28, OUT_SHIFT=15, DIV_CYCLES=16.
  - Enum state_t {LOAD, DIV, OUT}.
- One sub-module, recip_div_seq: start, sum in, 16-cycle restoring divider, done, quotient out. The multiply uses the existing mul_fast with IN_DW=16 unsigned-extended, or a plain * operator.

Test Plan:
- Row {2000,2000,2000,2000}h: sum=8000h, recip=2000h -> outputs 0800h x4, O_LAST on the 4th, O_ERR=0, first O_VALID 17 cycles after the last accept.
- Row {2000,1000,1000,0000}h: sum=4000h, recip=4000h -> outputs 1000h, 0800h, 0800h, 0000h.
- Row {2000,0,0,0}h: recip=8000h -> outputs 2000h, 0, 0, 0.
- Underflow row {0400h x4}: sum=1000h -> O_ERR=1 for the whole OUT phase, recip=8000h, outputs 0400h x4. O_ERR clears after O_LAST.
- Backpressure: I_READY toggled 1,0,0,1,... during OUT -> no output lost or duplicated, O_DATA stable while stalled. O_READY=0 throughout DIV and OUT even with I_VALID held high.
- Reset asserted at DIV cycle 8, then released and a new row {2000h x4} sent -> only that row's 0800h x4 appears; O_ERR=0.
